// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap engine.
//   - fir_state_t : sequencer state encoding (IDLE, WRITE, READ, DRAIN, OUT)
//   - clog2       : ceiling log2 for parameter derivation
//   - acc_width   : accumulator width, DWIDTH + CWIDTH + clog2(NTAPS)
package fir_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } fir_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Wide enough that NTAPS full-scale products can never overflow.
    function automatic int acc_width(input int dwidth, input int cwidth, input int ntaps);
        return dwidth + cwidth + clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate for the FIR tap engine.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clear      : zero the accumulator (has priority over i_en)
//   i_en         : add the current product on this clock
//   i_mask       : product is treated as zero (tap beyond filled history)
//   i_sample     : signed sample operand
//   i_coef       : signed coefficient operand
//   o_acc_next   : value the accumulator takes at the next edge when enabled;
//                  equals the held accumulator when i_en is low
module fir_mac
    import fir_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 8,
    parameter int ACCW   = 20
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_en,
    input  logic                     i_mask,
    input  logic signed [DWIDTH-1:0] i_sample,
    input  logic signed [CWIDTH-1:0] i_coef,
    output logic signed [ACCW-1:0]   o_acc_next
);

    localparam int PW = DWIDTH + CWIDTH;

    logic signed [PW-1:0]   w_prod;
    logic signed [ACCW-1:0] w_prod_ext;
    logic signed [ACCW-1:0] w_acc_next;
    logic signed [ACCW-1:0] r_acc;

    assign w_prod     = i_sample * i_coef;
    assign w_prod_ext = {{(ACCW-PW){w_prod[PW-1]}}, w_prod};

    always_comb begin
        w_acc_next = r_acc;
        if (i_en && !i_mask) begin
            w_acc_next = r_acc + w_prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

    assign o_acc_next = w_acc_next;

endmodule

// File: rtl/fir_tap_engine.sv
// FIR tap sequencer and MAC engine around an external dual-port sample RAM.
// Each accepted sample is written at a circular pointer, then the newest
// NTAPS samples are read back and multiplied by c[k] from an external
// registered coefficient store; one result is emitted per input sample.
// Optional feature macro: FIR_TAP_RNDSAT_EN -- when defined, out_data is
// DWIDTH wide, rounded by 2^(SHIFT-1), shifted right by SHIFT and saturated.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data      : input sample handshake
//   ram_we/ram_waddr/ram_wdata     : RAM write port
//   ram_re/ram_raddr/ram_q         : RAM read port, 1-cycle read latency
//   coef_addr/coef_q               : coefficient store, 1-cycle latency
//   out_valid/out_ready/out_data   : result handshake
module fir_tap_engine
    import fir_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8,
    parameter int CWIDTH = 8,
    parameter int NTAPS  = 16,
    parameter int SHIFT  = CWIDTH - 1,
    localparam int ACCW  = acc_width(DWIDTH, CWIDTH, NTAPS),
`ifdef FIR_TAP_RNDSAT_EN
    localparam int OUTW  = DWIDTH
`else
    localparam int OUTW  = ACCW
`endif
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DWIDTH-1:0] in_data,
    output logic                     ram_we,
    output logic [AWIDTH-1:0]        ram_waddr,
    output logic [DWIDTH-1:0]        ram_wdata,
    output logic                     ram_re,
    output logic [AWIDTH-1:0]        ram_raddr,
    input  logic signed [DWIDTH-1:0] ram_q,
    output logic [AWIDTH-1:0]        coef_addr,
    input  logic signed [CWIDTH-1:0] coef_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUTW-1:0]   out_data
);

    localparam int FILLW = clog2(NTAPS) + 1;
    localparam logic [AWIDTH-1:0] LAST_K = AWIDTH'(NTAPS - 1);

    generate
        if (NTAPS < 2 || NTAPS > (1 << AWIDTH) || SHIFT < 1 || SHIFT >= ACCW) begin : g_bad_params
            $error("fir_tap_engine: illegal parameter combination");
        end
    endgenerate

    fir_state_t              r_state;
    logic [AWIDTH-1:0]       r_wptr;
    logic [AWIDTH-1:0]       r_k;
    logic [FILLW-1:0]        r_fill;
    logic                    r_in_ready;
    logic                    r_ram_we;
    logic [AWIDTH-1:0]       r_ram_waddr;
    logic [DWIDTH-1:0]       r_ram_wdata;
    logic                    r_ram_re;
    logic [AWIDTH-1:0]       r_ram_raddr;
    logic [AWIDTH-1:0]       r_coef_addr;
    logic                    r_out_valid;
    logic signed [OUTW-1:0]  r_out_data;

    logic                    w_accept;
    logic                    w_mac_en;
    logic                    w_mask;
    logic [AWIDTH-1:0]       w_tap;
    logic signed [ACCW-1:0]  w_acc_next;
    logic signed [OUTW-1:0]  w_out;

    assign w_accept = (r_state == S_IDLE) && r_in_ready && in_valid;

    // RAM/coef data seen during READ k belongs to tap k-1; DRAIN sees the last tap.
    assign w_tap    = (r_state == S_DRAIN) ? LAST_K : (r_k - 1'b1);
    assign w_mac_en = ((r_state == S_READ) && (r_k != '0)) || (r_state == S_DRAIN);
    // Taps older than the number of samples written since reset read stale RAM.
    assign w_mask   = (32'(w_tap) >= 32'(r_fill));

    fir_mac #(
        .DWIDTH (DWIDTH),
        .CWIDTH (CWIDTH),
        .ACCW   (ACCW)
    ) u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_accept),
        .i_en       (w_mac_en),
        .i_mask     (w_mask),
        .i_sample   (ram_q),
        .i_coef     (coef_q),
        .o_acc_next (w_acc_next)
    );

`ifdef FIR_TAP_RNDSAT_EN
    localparam logic signed [ACCW:0] RND_BIAS = (ACCW+1)'(1 << (SHIFT - 1));
    localparam logic signed [ACCW:0] SAT_MAX  = (ACCW+1)'((1 << (DWIDTH - 1)) - 1);
    localparam logic signed [ACCW:0] SAT_MIN  = -((ACCW+1)'(1 << (DWIDTH - 1)));

    logic signed [ACCW:0] w_biased;
    logic signed [ACCW:0] w_shifted;

    // One guard bit so the rounding bias cannot wrap the accumulator.
    always_comb begin
        w_biased  = $signed({w_acc_next[ACCW-1], w_acc_next}) + RND_BIAS;
        w_shifted = w_biased >>> SHIFT;
        if (w_shifted > SAT_MAX) begin
            w_out = {1'b0, {(DWIDTH-1){1'b1}}};
        end else if (w_shifted < SAT_MIN) begin
            w_out = {1'b1, {(DWIDTH-1){1'b0}}};
        end else begin
            w_out = w_shifted[DWIDTH-1:0];
        end
    end
`else
    assign w_out = w_acc_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_k         <= '0;
            r_fill      <= '0;
            r_in_ready  <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_waddr <= '0;
            r_ram_wdata <= '0;
            r_ram_re    <= 1'b0;
            r_ram_raddr <= '0;
            r_coef_addr <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_in_ready  <= 1'b0;
                        r_ram_we    <= 1'b1;
                        r_ram_waddr <= r_wptr;
                        r_ram_wdata <= in_data;
                        r_state     <= S_WRITE;
                    end else begin
                        r_in_ready  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_ram_we    <= 1'b0;
                    r_ram_re    <= 1'b1;
                    r_ram_raddr <= r_wptr;
                    r_coef_addr <= '0;
                    r_k         <= '0;
                    if (r_fill != FILLW'(NTAPS)) begin
                        r_fill <= r_fill + 1'b1;
                    end
                    r_state     <= S_READ;
                end
                S_READ: begin
                    if (r_k == LAST_K) begin
                        r_ram_re <= 1'b0;
                        r_state  <= S_DRAIN;
                    end else begin
                        r_k         <= r_k + 1'b1;
                        r_ram_raddr <= r_wptr - (r_k + 1'b1);
                        r_coef_addr <= r_k + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_wptr      <= r_wptr + 1'b1;
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_out;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign ram_we    = r_ram_we;
    assign ram_waddr = r_ram_waddr;
    assign ram_wdata = r_ram_wdata;
    assign ram_re    = r_ram_re;
    assign ram_raddr = r_ram_raddr;
    assign coef_addr = r_coef_addr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_fir_tap_engine.sv
// Self-checking bench for fir_tap_engine. Two instances run in lockstep:
// u_dut_a (AWIDTH=8) and u_dut_b (AWIDTH=2, so its write pointer wraps).
// Both use NTAPS=4 and share stimulus and the coefficient table.
module tb_fir_tap_engine;

`ifdef FIR_TAP_RNDSAT_EN
    localparam int OUTW = 8;
`else
    localparam int OUTW = 18;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic preload = 1'b0;
    logic signed [7:0] in_data = '0;

    logic in_ready_a, ram_we_a, ram_re_a, out_valid_a;
    logic [7:0] ram_waddr_a, ram_raddr_a, coef_addr_a, ram_wdata_a;
    logic signed [7:0] ram_q_a, coef_q_a;
    logic signed [OUTW-1:0] out_data_a;

    logic in_ready_b, ram_we_b, ram_re_b, out_valid_b;
    logic [1:0] ram_waddr_b, ram_raddr_b, coef_addr_b;
    logic [7:0] ram_wdata_b;
    logic signed [7:0] ram_q_b, coef_q_b;
    logic signed [OUTW-1:0] out_data_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [4];
    logic signed [7:0] coef_tab [4];

    int total = 0;
    int bad = 0;
    int wcnt = 0;
    int overlap_cnt = 0;
    longint cyc = 0;
    longint t_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_tap_engine #(.DWIDTH(8), .AWIDTH(8), .CWIDTH(8), .NTAPS(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .ram_we(ram_we_a), .ram_waddr(ram_waddr_a), .ram_wdata(ram_wdata_a),
        .ram_re(ram_re_a), .ram_raddr(ram_raddr_a), .ram_q(ram_q_a),
        .coef_addr(coef_addr_a), .coef_q(coef_q_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
    );

    fir_tap_engine #(.DWIDTH(8), .AWIDTH(2), .CWIDTH(8), .NTAPS(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .ram_we(ram_we_b), .ram_waddr(ram_waddr_b), .ram_wdata(ram_wdata_b),
        .ram_re(ram_re_b), .ram_raddr(ram_raddr_b), .ram_q(ram_q_b),
        .coef_addr(coef_addr_b), .coef_q(coef_q_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
    );

    // Sample RAMs (registered read) and coefficient store.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 8'h55;
            for (int i = 0; i < 4; i++) mem_b[i] <= 8'h55;
        end else begin
            if (ram_we_a) mem_a[ram_waddr_a] <= ram_wdata_a;
            if (ram_we_b) mem_b[ram_waddr_b] <= ram_wdata_b;
        end
        if (ram_re_a) ram_q_a <= mem_a[ram_raddr_a];
        if (ram_re_b) ram_q_b <= mem_b[ram_raddr_b];
        coef_q_a <= coef_tab[coef_addr_a[1:0]];
        coef_q_b <= coef_tab[coef_addr_b];
    end

    always @(negedge clk) begin
        if ((ram_we_a && ram_re_a) || (ram_we_b && ram_re_b)) overlap_cnt <= overlap_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    function automatic longint fmt(input longint raw);
`ifdef FIR_TAP_RNDSAT_EN
        longint r;
        r = (raw + 64) >>> 7;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
`else
        return raw;
`endif
    endfunction

    task automatic set_coefs(input logic [31:0] c);
        for (int i = 0; i < 4; i++) coef_tab[i] = c[31-8*i -: 8];
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_a"}, {in_ready_a, ram_we_a, ram_re_a, out_valid_a, coef_addr_a,
                          ram_waddr_a, ram_raddr_a, ram_wdata_a, out_data_a}, 0);
        chk({tag, "_b"}, {in_ready_b, ram_we_b, ram_re_b, out_valid_b, coef_addr_b,
                          ram_waddr_b, ram_raddr_b, ram_wdata_b, out_data_b}, 0);
    endtask

    task automatic do_reset(input bit preload_en);
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; preload = preload_en;
        @(negedge clk);
        check_zero_outputs("reset_state");
        @(posedge clk); #1;
        preload = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wcnt = 0;
        chk("in_ready_before_first_clk", in_ready_a, 0);
        @(posedge clk); #1;
        chk("in_ready_after_first_clk", {in_ready_a, in_ready_b}, 2'b11);
    endtask

    task automatic accept(input logic signed [7:0] s);
        int g = 0;
        while (!in_ready_a && g < 64) begin
            @(posedge clk); #1;
            g++;
        end
        chk("in_ready_wait", in_ready_a, 1);
        in_valid = 1'b1; in_data = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t_acc = cyc;
        chk("write_cycle_we_re", {ram_we_a, ram_re_a, ram_we_b, ram_re_b}, 4'b1010);
        chk("waddr_a", ram_waddr_a, wcnt % 256);
        chk("waddr_b", ram_waddr_b, wcnt % 4);
        chk("wdata", ram_wdata_a, {s});
        wcnt++;
    endtask

    task automatic wait_out(output longint ra, output longint rb, output longint lat);
        int g = 0;
        @(negedge clk);
        while (!out_valid_a && g < 64) begin
            @(negedge clk);
            g++;
        end
        lat = cyc - t_acc;
        ra = out_data_a;
        rb = out_data_b;
        chk("out_valid_b", out_valid_b, 1);
    endtask

    task automatic finish_out(input int hold, input longint want);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_data_stable", out_data_a, want);
            chk("bp_flags", {in_ready_a, out_valid_a}, 2'b01);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_after_handshake", {in_ready_a, out_valid_a}, 2'b10);
    endtask

    typedef struct {
        bit                rst;
        logic [31:0]       coefs;
        logic signed [7:0] sample;
        int                hold;
        longint            want;
    } vec_t;

    function automatic vec_t mk(input bit r, input logic [31:0] c, input logic signed [7:0] s,
                                input int h, input longint w);
        vec_t v;
        v.rst = r; v.coefs = c; v.sample = s; v.hold = h; v.want = w;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        longint ra, rb, lat;
        longint t0;
        vec_t v;

`ifdef FIR_TAP_RNDSAT_EN
        // 127*127 = 16129 -> 126; two or more taps saturate to 127.
        vecs.push_back(mk(1, 32'h7F7F7F7F,  127, 0,  126));
        vecs.push_back(mk(0, 32'h7F7F7F7F,  127, 0,  127));
        vecs.push_back(mk(0, 32'h7F7F7F7F,  127, 5,  127));
        vecs.push_back(mk(0, 32'h7F7F7F7F,  127, 0,  127));
        // -128*127 = -16256 -> -126.5 floors to -127; then saturates to -128.
        vecs.push_back(mk(1, 32'h7F7F7F7F, -128, 0, -127));
        vecs.push_back(mk(0, 32'h7F7F7F7F, -128, 0, -128));
        vecs.push_back(mk(0, 32'h7F7F7F7F, -128, 0, -128));
        vecs.push_back(mk(0, 32'h7F7F7F7F, -128, 0, -128));
`else
        // Impulse over stale 0x55 RAM: fill masking keeps history at zero.
        vecs.push_back(mk(1, 32'h01020304, 1, 0, 1));
        vecs.push_back(mk(0, 32'h01020304, 0, 0, 2));
        vecs.push_back(mk(0, 32'h01020304, 0, 5, 3));
        vecs.push_back(mk(0, 32'h01020304, 0, 0, 4));
        vecs.push_back(mk(0, 32'h01020304, 0, 0, 0));
        // Ramp 1..6; the AWIDTH=2 instance wraps its write pointer.
        vecs.push_back(mk(0, 32'h01020304, 1, 0, 1));
        vecs.push_back(mk(0, 32'h01020304, 2, 0, 4));
        vecs.push_back(mk(0, 32'h01020304, 3, 0, 10));
        vecs.push_back(mk(0, 32'h01020304, 4, 0, 20));
        vecs.push_back(mk(0, 32'h01020304, 5, 0, 30));
        vecs.push_back(mk(0, 32'h01020304, 6, 0, 40));
        // First sample after reset with stale RAM.
        vecs.push_back(mk(1, 32'h01020304, 10, 0, 10));
        // Full scale: -128 * -128 per tap.
        vecs.push_back(mk(1, 32'h80808080, -128, 0, 16384));
        vecs.push_back(mk(0, 32'h80808080, -128, 0, 32768));
        vecs.push_back(mk(0, 32'h80808080, -128, 0, 49152));
        vecs.push_back(mk(0, 32'h80808080, -128, 0, 65536));
        vecs.push_back(mk(0, 32'h80808080, -128, 0, 65536));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            set_coefs(v.coefs);
            if (v.rst) do_reset(1'b1);
            accept(v.sample);
            wait_out(ra, rb, lat);
            chk("latency", lat, 6);
            chk("out_a", ra, v.want);
            chk("out_b", rb, v.want);
            $display("vec %0d: in=%0d out_a=%0d out_b=%0d want=%0d lat=%0d",
                     i, v.sample, ra, rb, v.want, lat);
            finish_out(v.hold, v.want);
        end

        // in_valid coincident with the output handshake is taken one cycle later.
        set_coefs(32'h01020304);
        do_reset(1'b1);
        accept(5);
        t0 = t_acc;
        wait_out(ra, rb, lat);
        chk("hs_first_out", ra, fmt(5));
        $display("seq hs1: in=5 out=%0d want=%0d lat=%0d", ra, fmt(5), lat);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 3;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("no_accept_on_handshake", {ram_we_a, in_ready_a}, 2'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        t_acc = cyc;
        chk("accept_in_idle", ram_we_a, 1);
        chk("min_sample_period", t_acc - t0, 8);
        chk("waddr_second", ram_waddr_a, 1);
        wcnt = 2;
        wait_out(ra, rb, lat);
        chk("hs_second_out", ra, fmt(13));
        chk("hs_second_lat", lat, 6);
        $display("seq hs2: in=3 out=%0d want=%0d lat=%0d", ra, fmt(13), lat);
        finish_out(0, fmt(13));

        // Reset during READ: everything clears and the next sample is the first.
        do_reset(1'b1);
        accept(7);
        repeat (3) @(negedge clk);
        chk("mid_read_re", ram_re_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_read_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        wcnt = 0;
        @(posedge clk); #1;
        accept(10);
        wait_out(ra, rb, lat);
        chk("after_reset_out_a", ra, fmt(10));
        chk("after_reset_out_b", rb, fmt(10));
        $display("seq rst: in=10 out=%0d want=%0d lat=%0d", ra, fmt(10), lat);
        finish_out(0, fmt(10));

        repeat (2) @(negedge clk);
        chk("we_re_exclusive", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
